// File: rtl/slide_pkg.sv
// Shared state type, geometry constants and circular index helpers for the
// slideshow scheduler.
package slide_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    PEND  = 2'd2,
    SLIDE = 2'd3
  } state_t;

  localparam logic [22:0] RANGE_ADDR_IMG = 23'd768000;
  localparam int          MAX_IMG        = 21;
  localparam int          H_RES          = 800;
  localparam int          SLIDE_STEP     = 40;

  // Indices wrap over the effective image count n (n >= 1 when used).
  function automatic logic [4:0] nextIdx(input logic [4:0] idx, input logic [4:0] n);
    return (idx == n - 5'd1) ? 5'd0 : idx + 5'd1;
  endfunction

  function automatic logic [4:0] prevIdx(input logic [4:0] idx, input logic [4:0] n);
    return (idx == 5'd0) ? n - 5'd1 : idx - 5'd1;
  endfunction

endpackage

// File: rtl/img_addr_calc.sv
// Turns an image index into its SDRAM read window: product register, then
// base/max registers, giving two cycles of latency from the index.
module img_addr_calc
  import slide_pkg::*;
(
  input  logic        iCLK_33,
  input  logic        iRST,
  input  logic [4:0]  idx,
  output logic [23:0] baseAddr,
  output logic [23:0] maxAddr
);

  logic [23:0] prod;

  always_ff @(posedge iCLK_33 or posedge iRST) begin
    if (iRST) begin
      prod     <= '0;
      baseAddr <= '0;
      maxAddr  <= {1'b0, RANGE_ADDR_IMG};
    end else begin
      prod     <= {19'd0, idx} * {1'b0, RANGE_ADDR_IMG};
      baseAddr <= prod;
      maxAddr  <= prod + {1'b0, RANGE_ADDR_IMG};
    end
  end

endmodule

// File: rtl/slide_sched.sv
// Frame-synchronous slideshow scheduler: owns current/target image indices,
// runs gesture-triggered slide transitions and drives both SDRAM read windows.
module slide_sched
  import slide_pkg::*;
(
  input  logic        iCLK_33,
  input  logic        iRST,
  input  logic [7:0]  iImg_Tot,
  input  logic        iLoad_Done,
  input  logic        iGest_E,
  input  logic        iGest_W,
  input  logic        iNew_Frame,
  input  logic        iEnd_Frame,
  output logic [23:0] oBase_Addr1,
  output logic [23:0] oMax_Addr1,
  output logic [23:0] oBase_Addr2,
  output logic [23:0] oMax_Addr2,
  output logic        oRd_Load,
  output logic [4:0]  oCur_Img,
  output logic [4:0]  oTgt_Img,
  output logic [9:0]  oShift,
  output logic        oDir,
  output logic        oBusy
);

  localparam logic [4:0] MAX_N     = 5'(MAX_IMG);
  localparam logic [9:0] STEP      = 10'(SLIDE_STEP);
  localparam logic [9:0] END_SHIFT = 10'(H_RES);

  state_t      state;
  logic [4:0]  cur;
  logic [4:0]  tgt;
  logic [4:0]  nEff;
  logic [9:0]  shift;
  logic        dir;
  logic [1:0]  startDly;
  logic        rdLoad;
  logic        canRun;
  logic        gestOne;
  logic        enterShow;

  always_comb begin
    nEff = (iImg_Tot > 8'(MAX_IMG)) ? MAX_N : iImg_Tot[4:0];
  end

  assign canRun    = iLoad_Done && (nEff != 5'd0);
  assign gestOne   = iGest_E ^ iGest_W;
  assign enterShow = canRun && iEnd_Frame && (state == IDLE);

  // Losing the image set (load dropped or count zero) parks the block in IDLE
  // from any state; otherwise every transition is gated by iEnd_Frame except
  // the gesture capture in SHOW.
  always_ff @(posedge iCLK_33 or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
      cur   <= '0;
      tgt   <= '0;
      shift <= '0;
      dir   <= 1'b0;
    end else if (!canRun) begin
      state <= IDLE;
      cur   <= '0;
      tgt   <= '0;
      shift <= '0;
      dir   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iEnd_Frame) begin
            state <= SHOW;
            cur   <= '0;
            tgt   <= nextIdx(5'd0, nEff);
          end
        end
        SHOW: begin
          tgt <= nextIdx(cur, nEff);
          if (gestOne && (nEff != 5'd1)) begin
            dir   <= iGest_E;
            state <= PEND;
          end
        end
        PEND: begin
          if (iEnd_Frame) begin
            tgt   <= dir ? prevIdx(cur, nEff) : nextIdx(cur, nEff);
            shift <= '0;
            state <= SLIDE;
          end
        end
        SLIDE: begin
          if (iEnd_Frame) begin
            if (shift + STEP == END_SHIFT) begin
              cur   <= tgt;
              tgt   <= nextIdx(tgt, nEff);
              shift <= '0;
              state <= SHOW;
            end else begin
              shift <= shift + STEP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The start-up reload waits until the first address windows have settled.
  always_ff @(posedge iCLK_33 or posedge iRST) begin
    if (iRST) begin
      startDly <= '0;
      rdLoad   <= 1'b0;
    end else begin
      startDly <= {startDly[0], enterShow};
      rdLoad   <= iNew_Frame | startDly[1];
    end
  end

  img_addr_calc addrCur (
    .iCLK_33  (iCLK_33),
    .iRST     (iRST),
    .idx      (cur),
    .baseAddr (oBase_Addr1),
    .maxAddr  (oMax_Addr1)
  );

  img_addr_calc addrTgt (
    .iCLK_33  (iCLK_33),
    .iRST     (iRST),
    .idx      (tgt),
    .baseAddr (oBase_Addr2),
    .maxAddr  (oMax_Addr2)
  );

  assign oRd_Load = rdLoad;
  assign oCur_Img = cur;
  assign oTgt_Img = tgt;
  assign oShift   = shift;
  assign oDir     = dir;
  assign oBusy    = (state == PEND) || (state == SLIDE);

endmodule

// File: tb/tb_slide_sched.sv
// Self-checking bench for slide_sched: table-driven slide scenarios, hand
// sequences for corner cases, and a reload-pulse scoreboard.
module tb_slide_sched;

  logic        iCLK_33 = 1'b0;
  logic        iRST;
  logic [7:0]  iImg_Tot;
  logic        iLoad_Done;
  logic        iGest_E;
  logic        iGest_W;
  logic        iNew_Frame;
  logic        iEnd_Frame;
  logic [23:0] oBase_Addr1;
  logic [23:0] oMax_Addr1;
  logic [23:0] oBase_Addr2;
  logic [23:0] oMax_Addr2;
  logic        oRd_Load;
  logic [4:0]  oCur_Img;
  logic [4:0]  oTgt_Img;
  logic [9:0]  oShift;
  logic        oDir;
  logic        oBusy;

  int cyc = 0;
  int assertCount = 0;
  int failCount = 0;
  int expQ[$];

  typedef struct {
    logic [7:0]  imgTot;
    bit          gestE;
    bit          gestW;
    bit          expShow;
    logic [4:0]  expTgt0;
    bit          expBusy;
    logic [4:0]  expCur;
    logic [4:0]  expTgt;
    logic [23:0] expBase1;
    logic [23:0] expMax1;
    logic [23:0] expBase2;
    logic [23:0] expMax2;
  } vec_t;

  vec_t vecs[7];

  slide_sched dut (
    .iCLK_33     (iCLK_33),
    .iRST        (iRST),
    .iImg_Tot    (iImg_Tot),
    .iLoad_Done  (iLoad_Done),
    .iGest_E     (iGest_E),
    .iGest_W     (iGest_W),
    .iNew_Frame  (iNew_Frame),
    .iEnd_Frame  (iEnd_Frame),
    .oBase_Addr1 (oBase_Addr1),
    .oMax_Addr1  (oMax_Addr1),
    .oBase_Addr2 (oBase_Addr2),
    .oMax_Addr2  (oMax_Addr2),
    .oRd_Load    (oRd_Load),
    .oCur_Img    (oCur_Img),
    .oTgt_Img    (oTgt_Img),
    .oShift      (oShift),
    .oDir        (oDir),
    .oBusy       (oBusy)
  );

  always #15 iCLK_33 = ~iCLK_33;

  always @(posedge iCLK_33) cyc <= cyc + 1;

  // Every reload pulse must match the oldest expected cycle in the queue.
  always @(negedge iCLK_33) begin
    int e;
    if (oRd_Load) begin
      assertCount++;
      if (expQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL rdLoadUnexpected: pulse at cycle %0d, none required", cyc);
      end else begin
        e = expQ.pop_front();
        if (e != cyc) begin
          failCount++;
          $display("[TB] FAIL rdLoadTiming: pulse at cycle %0d, required cycle %0d", cyc, e);
        end
      end
    end else if (expQ.size() != 0 && expQ[0] < cyc) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL rdLoadMissing: no pulse by cycle %0d, required at %0d", cyc, expQ[0]);
      void'(expQ.pop_front());
    end
  end

  task automatic tick();
    @(posedge iCLK_33);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // One cycle of pulses; any iNew_Frame books its reload one cycle later.
  task automatic applyStimulus(input bit endF, input bit newF, input bit gE, input bit gW);
    iEnd_Frame = endF;
    iNew_Frame = newF;
    iGest_E    = gE;
    iGest_W    = gW;
    if (newF) expQ.push_back(cyc + 1);
    tick();
    iEnd_Frame = 1'b0;
    iNew_Frame = 1'b0;
    iGest_E    = 1'b0;
    iGest_W    = 1'b0;
  endtask

  task automatic endFrame(input bit startReload);
    if (startReload) expQ.push_back(cyc + 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cur"},   32'(oCur_Img),    32'd0);
    checkOutput({tag, "_tgt"},   32'(oTgt_Img),    32'd0);
    checkOutput({tag, "_shift"}, 32'(oShift),      32'd0);
    checkOutput({tag, "_dir"},   32'(oDir),        32'd0);
    checkOutput({tag, "_busy"},  32'(oBusy),       32'd0);
    checkOutput({tag, "_load"},  32'(oRd_Load),    32'd0);
    checkOutput({tag, "_base1"}, 32'(oBase_Addr1), 32'd0);
    checkOutput({tag, "_max1"},  32'(oMax_Addr1),  32'd768000);
    checkOutput({tag, "_base2"}, 32'(oBase_Addr2), 32'd0);
    checkOutput({tag, "_max2"},  32'(oMax_Addr2),  32'd768000);
  endtask

  task automatic runVector(input int i, input vec_t v);
    string p;
    p = $sformatf("vec%0d", i);
    iLoad_Done = 1'b0;
    repeat (3) tick();
    iImg_Tot   = v.imgTot;
    iLoad_Done = 1'b1;
    tick();
    endFrame(v.expShow);
    checkOutput({p, "_cur0"},  32'(oCur_Img), 32'd0);
    checkOutput({p, "_tgt0"},  32'(oTgt_Img), 32'(v.expTgt0));
    applyStimulus(1'b0, 1'b0, v.gestE, v.gestW);
    checkOutput({p, "_busy"},  32'(oBusy), 32'(v.expBusy));
    repeat (21) endFrame(1'b0);
    checkOutput({p, "_cur"},   32'(oCur_Img),    32'(v.expCur));
    checkOutput({p, "_tgt"},   32'(oTgt_Img),    32'(v.expTgt));
    checkOutput({p, "_shift"}, 32'(oShift),      32'd0);
    checkOutput({p, "_idle"},  32'(oBusy),       32'd0);
    checkOutput({p, "_base1"}, 32'(oBase_Addr1), 32'(v.expBase1));
    checkOutput({p, "_max1"},  32'(oMax_Addr1),  32'(v.expMax1));
    checkOutput({p, "_base2"}, 32'(oBase_Addr2), 32'(v.expBase2));
    checkOutput({p, "_max2"},  32'(oMax_Addr2),  32'(v.expMax2));
  endtask

  initial begin
    vecs[0] = '{8'd3,  1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2,  5'd0, 24'd1536000,  24'd2304000,  24'd0,       24'd768000};
    vecs[1] = '{8'd3,  1'b0, 1'b1, 1'b1, 5'd1, 1'b1, 5'd1,  5'd2, 24'd768000,   24'd1536000,  24'd1536000, 24'd2304000};
    vecs[2] = '{8'd40, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd20, 5'd0, 24'd15360000, 24'd16128000, 24'd0,       24'd768000};
    vecs[3] = '{8'd2,  1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd1,  5'd0, 24'd768000,   24'd1536000,  24'd0,       24'd768000};
    vecs[4] = '{8'd1,  1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0,  5'd0, 24'd0,        24'd768000,   24'd0,       24'd768000};
    vecs[5] = '{8'd0,  1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  5'd0, 24'd0,        24'd768000,   24'd0,       24'd768000};
    vecs[6] = '{8'd21, 1'b0, 1'b1, 1'b1, 5'd1, 1'b1, 5'd1,  5'd2, 24'd768000,   24'd1536000,  24'd1536000, 24'd2304000};

    iRST       = 1'b1;
    iImg_Tot   = 8'd0;
    iLoad_Done = 1'b0;
    iGest_E    = 1'b0;
    iGest_W    = 1'b0;
    iNew_Frame = 1'b0;
    iEnd_Frame = 1'b0;
    repeat (3) tick();
    checkResetValues("reset");
    iRST = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) runVector(i, vecs[i]);

    // Bring-up with three images.
    iLoad_Done = 1'b0;
    repeat (3) tick();
    iImg_Tot   = 8'd3;
    iLoad_Done = 1'b1;
    tick();
    endFrame(1'b1);
    checkOutput("bringup_cur",   32'(oCur_Img),    32'd0);
    checkOutput("bringup_tgt",   32'(oTgt_Img),    32'd1);
    checkOutput("bringup_base2", 32'(oBase_Addr2), 32'd768000);
    checkOutput("bringup_max2",  32'(oMax_Addr2),  32'd1536000);

    // East slide from image 0 wraps to image 2, shift walks 0..760.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("east_pendBusy", 32'(oBusy),    32'd1);
    checkOutput("east_pendDir",  32'(oDir),     32'd1);
    checkOutput("east_pendTgt",  32'(oTgt_Img), 32'd1);
    endFrame(1'b0);
    checkOutput("east_tgt",      32'(oTgt_Img), 32'd2);
    checkOutput("east_shift0",   32'(oShift),   32'd0);
    for (int k = 1; k < 20; k++) begin
      endFrame(1'b0);
      checkOutput($sformatf("east_shift%0d", k), 32'(oShift), 32'(40 * k));
    end
    endFrame(1'b0);
    checkOutput("east_cur",   32'(oCur_Img),    32'd2);
    checkOutput("east_tgt2",  32'(oTgt_Img),    32'd0);
    checkOutput("east_shift", 32'(oShift),      32'd0);
    checkOutput("east_busy",  32'(oBusy),       32'd0);
    checkOutput("east_base1", 32'(oBase_Addr1), 32'd1536000);
    checkOutput("east_max1",  32'(oMax_Addr1),  32'd2304000);

    // West slide from image 2 wraps to 0; a gesture mid-slide is dropped and
    // one frame carries both frame pulses together.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("west_dir", 32'(oDir), 32'd0);
    endFrame(1'b0);
    checkOutput("west_tgt", 32'(oTgt_Img), 32'd0);
    repeat (2) endFrame(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("west_ignBusy",  32'(oBusy),    32'd1);
    checkOutput("west_ignTgt",   32'(oTgt_Img), 32'd0);
    checkOutput("west_ignShift", 32'(oShift),   32'd80);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("west_bothShift", 32'(oShift), 32'd120);
    repeat (17) endFrame(1'b0);
    checkOutput("west_cur",  32'(oCur_Img), 32'd0);
    checkOutput("west_tgt2", 32'(oTgt_Img), 32'd1);
    checkOutput("west_busy", 32'(oBusy),    32'd0);

    // Simultaneous gestures are ignored.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("both_busy", 32'(oBusy), 32'd0);
    endFrame(1'b0);
    checkOutput("both_busy2", 32'(oBusy),    32'd0);
    checkOutput("both_cur",   32'(oCur_Img), 32'd0);

    // Gesture on the iEnd_Frame edge only resolves at the following frame.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("coin_busy", 32'(oBusy),    32'd1);
    checkOutput("coin_tgt",  32'(oTgt_Img), 32'd1);
    tick();
    tick();
    endFrame(1'b0);
    checkOutput("coin_tgt2",  32'(oTgt_Img), 32'd2);
    checkOutput("coin_shift", 32'(oShift),   32'd0);
    repeat (10) endFrame(1'b0);
    checkOutput("coin_shift400", 32'(oShift), 32'd400);

    // Asynchronous reset in the middle of a slide.
    iRST = 1'b1;
    #1;
    checkResetValues("midReset");
    tick();
    iRST = 1'b0;
    tick();

    // Dropping iLoad_Done mid-slide returns to IDLE on the next edge.
    endFrame(1'b1);
    checkOutput("drop_cur0", 32'(oCur_Img), 32'd0);
    checkOutput("drop_tgt0", 32'(oTgt_Img), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (21) endFrame(1'b0);
    checkOutput("drop_cur1", 32'(oCur_Img), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (11) endFrame(1'b0);
    checkOutput("drop_shift400", 32'(oShift),   32'd400);
    checkOutput("drop_tgt2",     32'(oTgt_Img), 32'd2);
    iLoad_Done = 1'b0;
    tick();
    checkOutput("drop_cur",   32'(oCur_Img), 32'd0);
    checkOutput("drop_tgt",   32'(oTgt_Img), 32'd0);
    checkOutput("drop_shift", 32'(oShift),   32'd0);
    checkOutput("drop_busy",  32'(oBusy),    32'd0);

    repeat (4) tick();
    checkOutput("rdLoadPending", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
